// File: rtl/ita_seg_pkg.sv
// Shared constants, 14-segment glyph table and ASCII-to-glyph decode for the message scroller and display.
// Segment order, MSB first: a b c d e f g1 g2 h(UL diag) i(up vert) j(UR diag) k(LR diag) l(low vert) m(LL diag).
package ita_seg_pkg;

  localparam int unsigned NUM_DIGITS = 12;
  localparam int unsigned MSG_DEPTH  = 32;
  localparam int unsigned CHAR_W     = 7;
  localparam int unsigned SEG_W      = 14;
  localparam int unsigned LEN_W      = 6;
  localparam int unsigned PTR_W      = 5;
  localparam int unsigned IDX_W      = 4;

  localparam logic [SEG_W-1:0] GLYPH_A = 14'b111011_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_B = 14'b111100_01_010010;
  localparam logic [SEG_W-1:0] GLYPH_C = 14'b100111_00_000000;
  localparam logic [SEG_W-1:0] GLYPH_D = 14'b111100_00_010010;
  localparam logic [SEG_W-1:0] GLYPH_E = 14'b100111_10_000000;
  localparam logic [SEG_W-1:0] GLYPH_F = 14'b100011_10_000000;
  localparam logic [SEG_W-1:0] GLYPH_G = 14'b101111_01_000000;
  localparam logic [SEG_W-1:0] GLYPH_H = 14'b011011_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_I = 14'b100100_00_010010;
  localparam logic [SEG_W-1:0] GLYPH_J = 14'b011110_00_000000;
  localparam logic [SEG_W-1:0] GLYPH_K = 14'b000011_10_001100;
  localparam logic [SEG_W-1:0] GLYPH_L = 14'b000111_00_000000;
  localparam logic [SEG_W-1:0] GLYPH_M = 14'b011011_00_101000;
  localparam logic [SEG_W-1:0] GLYPH_N = 14'b011011_00_100100;
  localparam logic [SEG_W-1:0] GLYPH_O = 14'b111111_00_000000;
  localparam logic [SEG_W-1:0] GLYPH_P = 14'b110011_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_Q = 14'b111111_00_000100;
  localparam logic [SEG_W-1:0] GLYPH_R = 14'b110011_11_000100;
  localparam logic [SEG_W-1:0] GLYPH_S = 14'b101101_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_T = 14'b100000_00_010010;
  localparam logic [SEG_W-1:0] GLYPH_U = 14'b011111_00_000000;
  localparam logic [SEG_W-1:0] GLYPH_V = 14'b000011_00_001001;
  localparam logic [SEG_W-1:0] GLYPH_W = 14'b011011_00_000101;
  localparam logic [SEG_W-1:0] GLYPH_X = 14'b000000_00_101101;
  localparam logic [SEG_W-1:0] GLYPH_Y = 14'b000000_00_101010;
  localparam logic [SEG_W-1:0] GLYPH_Z = 14'b100100_00_001001;
  localparam logic [SEG_W-1:0] GLYPH_0 = 14'b111111_00_001001;
  localparam logic [SEG_W-1:0] GLYPH_1 = 14'b011000_00_001000;
  localparam logic [SEG_W-1:0] GLYPH_2 = 14'b110110_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_3 = 14'b111100_01_000000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 14'b011001_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_5 = 14'b101101_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_6 = 14'b101111_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_7 = 14'b111000_00_000000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 14'b111111_11_000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 14'b111101_11_000000;

  // Lowercase folds onto uppercase; anything unmapped (space, punctuation) is blank.
  function automatic logic [SEG_W-1:0] ascii_to_glyph(input logic [CHAR_W-1:0] c);
    logic [CHAR_W-1:0] u;
    logic [SEG_W-1:0]  g;
    u = ((c >= 7'h61) && (c <= 7'h7A)) ? CHAR_W'(c - 7'h20) : c;
    g = '0;
    case (u)
      7'h41: g = GLYPH_A;
      7'h42: g = GLYPH_B;
      7'h43: g = GLYPH_C;
      7'h44: g = GLYPH_D;
      7'h45: g = GLYPH_E;
      7'h46: g = GLYPH_F;
      7'h47: g = GLYPH_G;
      7'h48: g = GLYPH_H;
      7'h49: g = GLYPH_I;
      7'h4A: g = GLYPH_J;
      7'h4B: g = GLYPH_K;
      7'h4C: g = GLYPH_L;
      7'h4D: g = GLYPH_M;
      7'h4E: g = GLYPH_N;
      7'h4F: g = GLYPH_O;
      7'h50: g = GLYPH_P;
      7'h51: g = GLYPH_Q;
      7'h52: g = GLYPH_R;
      7'h53: g = GLYPH_S;
      7'h54: g = GLYPH_T;
      7'h55: g = GLYPH_U;
      7'h56: g = GLYPH_V;
      7'h57: g = GLYPH_W;
      7'h58: g = GLYPH_X;
      7'h59: g = GLYPH_Y;
      7'h5A: g = GLYPH_Z;
      7'h30: g = GLYPH_0;
      7'h31: g = GLYPH_1;
      7'h32: g = GLYPH_2;
      7'h33: g = GLYPH_3;
      7'h34: g = GLYPH_4;
      7'h35: g = GLYPH_5;
      7'h36: g = GLYPH_6;
      7'h37: g = GLYPH_7;
      7'h38: g = GLYPH_8;
      7'h39: g = GLYPH_9;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ita_msg_scroller_if.sv
// Write, control and display-read signals of the message scroller.
interface ita_msg_scroller_if;
  import ita_seg_pkg::*;

  logic              wr_valid;
  logic [CHAR_W-1:0] wr_char;
  logic              wr_ready;
  logic              clear;
  logic              scroll_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [SEG_W-1:0]  rd_seg;
  logic [LEN_W-1:0]  msg_len;
  logic              step;

  modport master (
    output wr_valid, wr_char, clear, scroll_en, rd_idx,
    input  wr_ready, rd_seg, msg_len, step
  );

  modport slave (
    input  wr_valid, wr_char, clear, scroll_en, rd_idx,
    output wr_ready, rd_seg, msg_len, step
  );
endinterface

// File: rtl/ita_prescaler.sv
// Free-running divider that pulses tick on the last count of each DIV-cycle period while enabled.
module ita_prescaler #(
  parameter int unsigned DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Disabled means parked at zero, so every enable starts a full period.
  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == CNT_W'(DIV - 1)) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ita_msg_scroller.sv
// 32-character ASCII message buffer presented as a 12-digit, optionally circular-scrolling window.
module ita_msg_scroller
  import ita_seg_pkg::*;
#(
  parameter int unsigned SCROLL_DIV = 1000000
) (
`ifdef USE_POWER_PINS
  inout wire                  vdd,
  inout wire                  vss,
`endif
  input  logic                clk,
  input  logic                rst_n,
  ita_msg_scroller_if.slave   bus
);

  logic [CHAR_W-1:0] mem_q [MSG_DEPTH];
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic [PTR_W-1:0]  offset_q, offset_d;
  logic              step_q, step_d;
  logic [SEG_W-1:0]  rd_seg_q, rd_seg_d;
  logic              wr_ready_c;
  logic              wr_fire;
  logic              scroll_active;
  logic              tick;
  logic [LEN_W-1:0]  sum;
  logic [LEN_W-1:0]  idx;

  assign wr_ready_c    = (msg_len_q < LEN_W'(MSG_DEPTH)) && !bus.clear;
  assign wr_fire       = bus.wr_valid && wr_ready_c;
  assign scroll_active = bus.scroll_en && (msg_len_q > LEN_W'(NUM_DIGITS)) && !bus.clear;

  ita_prescaler #(.DIV(SCROLL_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scroll_active),
    .tick  (tick)
  );

  // Length, scroll offset and step pulse; clear overrides both write and advance.
  always_comb begin
    msg_len_d = msg_len_q;
    offset_d  = offset_q;
    step_d    = 1'b0;
    if (bus.clear) begin
      msg_len_d = '0;
      offset_d  = '0;
    end else begin
      if (wr_fire) msg_len_d = msg_len_q + LEN_W'(1);
      if (tick) begin
        step_d   = 1'b1;
        offset_d = ((LEN_W'(offset_q) + LEN_W'(1)) == msg_len_q) ? '0 : offset_q + PTR_W'(1);
      end
    end
  end

  // Window read: rotate by offset when scrolling, otherwise blank past the message end.
  always_comb begin
    sum      = LEN_W'(offset_q) + LEN_W'(bus.rd_idx);
    idx      = '0;
    rd_seg_d = '0;
    if (bus.rd_idx < IDX_W'(NUM_DIGITS)) begin
      if (msg_len_q > LEN_W'(NUM_DIGITS)) begin
        idx      = (sum >= msg_len_q) ? (sum - msg_len_q) : sum;
        rd_seg_d = ascii_to_glyph(mem_q[PTR_W'(idx)]);
      end else if (LEN_W'(bus.rd_idx) < msg_len_q) begin
        idx      = LEN_W'(bus.rd_idx);
        rd_seg_d = ascii_to_glyph(mem_q[PTR_W'(idx)]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len_q <= '0;
      offset_q  <= '0;
      step_q    <= 1'b0;
      rd_seg_q  <= '0;
    end else begin
      msg_len_q <= msg_len_d;
      offset_q  <= offset_d;
      step_q    <= step_d;
      rd_seg_q  <= rd_seg_d;
    end
  end

  // Character storage is deliberately unreset; msg_len gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[PTR_W'(msg_len_q)] <= bus.wr_char;
  end

  assign bus.wr_ready = wr_ready_c;
  assign bus.msg_len  = msg_len_q;
  assign bus.step     = step_q;
  assign bus.rd_seg   = rd_seg_q;

endmodule

// File: doc/ita_msg_scroller.md
ITA_MSG_SCROLLER -- requirements
Module: ita_msg_scroller

Interface
REQ-001 Parameter SCROLL_DIV, default 1000000, clk cycles per scroll step (legal range 2..2^24).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_valid  input  1  write request for wr_char.
REQ-005 wr_char  input  7  ASCII character to append.
REQ-006 wr_ready  output  1  buffer can accept a character.
REQ-007 clear  input  1  single-cycle pulse; empties the message.
REQ-008 scroll_en  input  1  enables scrolling.
REQ-009 rd_idx  input  4  digit position requested by the display multiplexer, 0 = leftmost.
REQ-010 rd_seg  output  14  glyph for rd_idx, bit 13 = segment a, same encoding as the 12-digit display.
REQ-011 msg_len  output  6  number of stored characters, 0..32.
REQ-012 step  output  1  one-cycle pulse on each scroll advance.
REQ-013 vdd/vss inout, present only under USE_POWER_PINS.

Function
REQ-014 Storage: 32 entries x 7-bit ASCII; glyph encoding applied on read, not on write.
REQ-015 wr_ready = (msg_len < 32) and not clear.
REQ-016 Write accepted when wr_valid and wr_ready: char stored at index msg_len; msg_len increments the next cycle.
REQ-017 Full (msg_len = 32): wr_ready low; held wr_valid is not accepted or lost, and waits.
REQ-018 clear: msg_len and offset become 0 the next cycle; a simultaneous write is not accepted.
REQ-019 Prescaler counts 0..SCROLL_DIV-1 only while scroll_en = 1 and msg_len > 12; otherwise it is held at 0.
REQ-020 At terminal count: prescaler returns to 0; offset becomes offset+1, or 0 when offset+1 = msg_len; step = 1 for that one cycle.
REQ-021 msg_len <= 12: offset is held at 0 and no step pulses occur.
REQ-022 Read, msg_len > 12: index = offset + rd_idx, minus msg_len if the sum >= msg_len (single subtraction; circular wrap).
REQ-023 Read, msg_len <= 12: index = rd_idx; blank (14'b0) when rd_idx >= msg_len.
REQ-024 rd_idx >= 12: rd_seg = 0.
REQ-025 rd_seg is registered, with 1-cycle latency from rd_idx.
REQ-026 A write during scrolling takes effect at the next read; offset is not adjusted.
REQ-027 Glyph map: A-Z and a-z map to uppercase glyphs; 0-9 map to digit glyphs; all other codes, including space, map to 0.
REQ-028 Glyph values include: A = 14'b11101111000000, E = 14'b10011110000000, K = 14'b00001110001100, L = 14'b00011100000000, R = 14'b11001111000100, S = 14'b10110111000000, Y = 14'b00000000101010.

Reset
REQ-029 While rst_n = 0, asynchronously: msg_len = 0, offset = 0, prescaler = 0, rd_seg = 0, step = 0.
REQ-030 Buffer contents are not reset; entries at or above msg_len are never displayed.
REQ-031 wr_ready = 1 in the first cycle after reset release.
REQ-032 Reset during scrolling discards the message (msg_len = 0); no partial step pulse is produced.

Structure
REQ-033 Package ita_seg_pkg holds:
- NUM_DIGITS = 12 and MSG_DEPTH = 32;
- the 36 glyph constants;
- the ascii_to_glyph function, which the existing display block also reuses.
REQ-034 Sub-module ita_prescaler (parameter DIV; inputs clk, rst_n, en; output tick) implements the step timing.

Verification
REQ-035 Reset, write "ESREAL" -> msg_len = 6. rd_idx = 0 -> rd_seg = 14'b10011110000000 one cycle later. rd_idx = 6..11 -> rd_seg = 0.
REQ-036 Write 32 characters -> wr_ready = 0 after the 32nd. A 33rd wr_valid held 10 cycles is not accepted and msg_len stays 32.
REQ-037 SCROLL_DIV = 4, write "ABCDEFGHIJKLMN", scroll_en = 1 ->
- step fires every 4 cycles;
- after 1 step, rd_idx 0 shows B;
- after 13 steps, rd_idx 0 shows N and rd_idx 1 shows A;
- after 14 steps, offset = 0.
REQ-038 clear and wr_valid in the same cycle -> msg_len = 0 and the character is not stored.
REQ-039 rst_n pulled low mid-scroll -> rd_seg, step and msg_len go to 0 without waiting for a clock edge; after release, scrolling stays idle.
REQ-040 Write 'k' and '#' -> rd_seg = 14'b00001110001100 and 14'b0 respectively.
